// File: rtl/register_file_sb.sv
// Parametrised register file with three registered read ports, write-to-read bypass,
// an optional hardwired zero register and a per-register busy scoreboard.
module register_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       bus_w,
  input  logic [ADDR_W-1:0]      addr_w,
  input  logic                   en_w,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [ADDR_W-1:0]      addr_d,
  input  logic                   en_a,
  input  logic                   en_b,
  input  logic                   en_d,
  output logic [WIDTH-1:0]       bus_a,
  output logic [WIDTH-1:0]       bus_b,
  output logic [WIDTH-1:0]       bus_d,
  output logic                   valid_a,
  output logic                   valid_b,
  output logic                   valid_d,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic                   busy_d,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_err,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NPORT = 3;

  logic [WIDTH-1:0]  regs    [DEPTH];
  logic [ADDR_W-1:0] rd_addr [NPORT];
  logic [WIDTH-1:0]  rd_data [NPORT];
  logic [WIDTH-1:0]  rd_q    [NPORT];
  logic [NPORT-1:0]  rd_en;
  logic [NPORT-1:0]  rd_busy;
  logic [NPORT-1:0]  busy_q;
  logic [NPORT-1:0]  valid_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rsv_hit;

  assign rd_addr[0] = addr_a;
  assign rd_addr[1] = addr_b;
  assign rd_addr[2] = addr_d;
  assign rd_en      = {en_d, en_b, en_a};

  // A write to the hardwired zero register is dropped entirely.
  assign wr_ok   = en_w && !(ZERO_REG != 0 && addr_w == '0);
  assign rsv_hit = rsv_en && busy_vec[rsv_addr];

  // NOTE: every variable gets its default before any conditional update, so no latch is inferred.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy_vec[rd_addr[p]];
      if (BYPASS != 0 && en_w && addr_w == rd_addr[p]) begin
        rd_busy[p] = 1'b0;
        if (wr_ok) rd_data[p] = bus_w;
      end
      if (ZERO_REG != 0 && rd_addr[p] == '0) rd_data[p] = '0;
    end
  end

  // Reserve is applied after the write clear so it wins on the same address.
  always_comb begin
    busy_nxt = busy_vec;
    if (en_w)           busy_nxt[addr_w]   = 1'b0;
    if (rsv_en)         busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0)  busy_nxt[0]        = 1'b0;
  end

  // NOTE: the storage array is reset because software relies on every register reading 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[addr_w] <= bus_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_vec <= '0;
      rsv_err  <= 1'b0;
      valid_q  <= '0;
      busy_q   <= '0;
      for (int p = 0; p < NPORT; p++) rd_q[p] <= '0;
    end else begin
      busy_vec <= busy_nxt;
      rsv_err  <= rsv_hit;
      valid_q  <= rd_en;
      for (int p = 0; p < NPORT; p++) begin
        if (rd_en[p]) begin
          rd_q[p]   <= rd_data[p];
          busy_q[p] <= rd_busy[p];
        end
      end
    end
  end

  assign bus_a   = rd_q[0];
  assign bus_b   = rd_q[1];
  assign bus_d   = rd_q[2];
  assign valid_a = valid_q[0];
  assign valid_b = valid_q[1];
  assign valid_d = valid_q[2];
  assign busy_a  = busy_q[0];
  assign busy_b  = busy_q[1];
  assign busy_d  = busy_q[2];

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a default instance (bypass, no zero register)
// and a 32x32 instance with zero register and no bypass.
module tb_register_file_sb;

  localparam int W0 = 16, A0 = 3, D0 = 8;
  localparam int W1 = 32, A1 = 5, D1 = 32;

  typedef struct {
    string       tag;
    int          port;
    logic [33:0] exp;
  } sb_item_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W0-1:0] bus_w0, bus_a0, bus_b0, bus_d0;
  logic [A0-1:0] addr_w0, addr_a0, addr_b0, addr_d0, rsv_addr0;
  logic          en_w0, en_a0, en_b0, en_d0, rsv_en0, rsv_err0;
  logic          valid_a0, valid_b0, valid_d0, busy_a0, busy_b0, busy_d0;
  logic [D0-1:0] busy_vec0;

  logic [W1-1:0] bus_w1, bus_a1, bus_b1, bus_d1;
  logic [A1-1:0] addr_w1, addr_a1, addr_b1, addr_d1, rsv_addr1;
  logic          en_w1, en_a1, en_b1, en_d1, rsv_en1, rsv_err1;
  logic          valid_a1, valid_b1, valid_d1, busy_a1, busy_b1, busy_d1;
  logic [D1-1:0] busy_vec1;

  register_file_sb #(.WIDTH(W0), .ADDR_W(A0), .ZERO_REG(0), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .bus_w(bus_w0), .addr_w(addr_w0), .en_w(en_w0),
    .addr_a(addr_a0), .addr_b(addr_b0), .addr_d(addr_d0),
    .en_a(en_a0), .en_b(en_b0), .en_d(en_d0),
    .bus_a(bus_a0), .bus_b(bus_b0), .bus_d(bus_d0),
    .valid_a(valid_a0), .valid_b(valid_b0), .valid_d(valid_d0),
    .busy_a(busy_a0), .busy_b(busy_b0), .busy_d(busy_d0),
    .rsv_en(rsv_en0), .rsv_addr(rsv_addr0), .rsv_err(rsv_err0), .busy_vec(busy_vec0)
  );

  register_file_sb #(.WIDTH(W1), .ADDR_W(A1), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .bus_w(bus_w1), .addr_w(addr_w1), .en_w(en_w1),
    .addr_a(addr_a1), .addr_b(addr_b1), .addr_d(addr_d1),
    .en_a(en_a1), .en_b(en_b1), .en_d(en_d1),
    .bus_a(bus_a1), .bus_b(bus_b1), .bus_d(bus_d1),
    .valid_a(valid_a1), .valid_b(valid_b1), .valid_d(valid_d1),
    .busy_a(busy_a1), .busy_b(busy_b1), .busy_d(busy_d1),
    .rsv_en(rsv_en1), .rsv_addr(rsv_addr1), .rsv_err(rsv_err1), .busy_vec(busy_vec1)
  );

  int          total = 0;
  int          bad   = 0;
  sb_item_t    sb [$];
  logic [31:0] mdl [2][32];
  logic [31:0] bvm [2];
  logic [31:0] last_d [6];
  logic        last_b [6];
  string       pname [6] = '{"a0", "b0", "d0", "a1", "b1", "d1"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {valid, busy, data} of one read port; ports 0..2 on dut0, 3..5 on dut1.
  function automatic logic [33:0] rd_act(input int p);
    case (p)
      0:       return {valid_a0, busy_a0, 16'h0, bus_a0};
      1:       return {valid_b0, busy_b0, 16'h0, bus_b0};
      2:       return {valid_d0, busy_d0, 16'h0, bus_d0};
      3:       return {valid_a1, busy_a1, bus_a1};
      4:       return {valid_b1, busy_b1, bus_b1};
      default: return {valid_d1, busy_d1, bus_d1};
    endcase
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      bvm[d] = '0;
      for (int i = 0; i < 32; i++) mdl[d][i] = '0;
    end
    for (int q = 0; q < 6; q++) begin
      last_d[q] = '0;
      last_b[q] = 1'b0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "/bus0"}, {bus_a0, bus_b0, bus_d0}, 64'h0);
    check({tag, "/flags0"}, 64'({valid_a0, valid_b0, valid_d0, busy_a0, busy_b0, busy_d0, rsv_err0}), 64'h0);
    check({tag, "/vec0"}, 64'(busy_vec0), 64'h0);
    check({tag, "/bus_a1"}, 64'(bus_a1), 64'h0);
    check({tag, "/bus_b1"}, 64'(bus_b1), 64'h0);
    check({tag, "/bus_d1"}, 64'(bus_d1), 64'h0);
    check({tag, "/flags1"}, 64'({valid_a1, valid_b1, valid_d1, busy_a1, busy_b1, busy_d1, rsv_err1}), 64'h0);
    check({tag, "/vec1"}, 64'(busy_vec1), 64'h0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero(tag);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  // One clock of stimulus on dut d; en bits are {d, b, a}. Entered and left at a falling edge.
  task automatic step(input int d, input logic ew, input int aw, input logic [31:0] dw_in,
                      input logic [2:0] en, input int aa, input int ab, input int ad,
                      input logic re, input int ra, input string tag);
    int          adr [3];
    int          q;
    logic [31:0] dw, bnew, vec_act;
    logic        zr, byp, wr_ok, exp_err, err_act;
    sb_item_t    it;
    adr = '{aa, ab, ad};
    zr  = (d == 1);
    byp = (d == 0);
    dw  = (d == 0) ? (dw_in & 32'h0000_FFFF) : dw_in;
    en_w0 = 1'b0; en_a0 = 1'b0; en_b0 = 1'b0; en_d0 = 1'b0; rsv_en0 = 1'b0;
    en_w1 = 1'b0; en_a1 = 1'b0; en_b1 = 1'b0; en_d1 = 1'b0; rsv_en1 = 1'b0;
    if (d == 0) begin
      bus_w0 = dw[W0-1:0]; addr_w0 = aw[A0-1:0]; en_w0 = ew;
      addr_a0 = aa[A0-1:0]; addr_b0 = ab[A0-1:0]; addr_d0 = ad[A0-1:0];
      en_a0 = en[0]; en_b0 = en[1]; en_d0 = en[2];
      rsv_en0 = re; rsv_addr0 = ra[A0-1:0];
    end else begin
      bus_w1 = dw; addr_w1 = aw[A1-1:0]; en_w1 = ew;
      addr_a1 = aa[A1-1:0]; addr_b1 = ab[A1-1:0]; addr_d1 = ad[A1-1:0];
      en_a1 = en[0]; en_b1 = en[1]; en_d1 = en[2];
      rsv_en1 = re; rsv_addr1 = ra[A1-1:0];
    end
    wr_ok = ew && !(zr && aw == 0);
    for (int p = 0; p < 3; p++) begin
      q = d * 3 + p;
      if (en[p]) begin
        if (zr && adr[p] == 0)                last_d[q] = '0;
        else if (byp && wr_ok && aw == adr[p]) last_d[q] = dw;
        else                                   last_d[q] = mdl[d][adr[p]];
        last_b[q] = bvm[d][adr[p]] && !(byp && ew && aw == adr[p]);
      end
      sb.push_back('{tag, q, {en[p], last_b[q], last_d[q]}});
    end
    exp_err = re && bvm[d][ra];
    if (wr_ok) mdl[d][aw] = dw;
    bnew = bvm[d];
    if (ew) bnew[aw] = 1'b0;
    if (re) bnew[ra] = 1'b1;
    if (zr) bnew[0]  = 1'b0;
    bvm[d] = bnew;

    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check({it.tag, "/", pname[it.port]}, 64'(rd_act(it.port)), 64'(it.exp));
    end
    err_act = (d == 0) ? rsv_err0 : rsv_err1;
    vec_act = (d == 0) ? {24'h0, busy_vec0} : busy_vec1;
    check({tag, "/rsv_err"}, 64'(err_act), 64'(exp_err));
    check({tag, "/busy_vec"}, 64'(vec_act), 64'(bvm[d]));
    @(negedge clk);
  endtask

  initial begin
    bus_w0 = '0; addr_w0 = '0; addr_a0 = '0; addr_b0 = '0; addr_d0 = '0; rsv_addr0 = '0;
    en_w0 = 1'b0; en_a0 = 1'b0; en_b0 = 1'b0; en_d0 = 1'b0; rsv_en0 = 1'b0;
    bus_w1 = '0; addr_w1 = '0; addr_a1 = '0; addr_b1 = '0; addr_d1 = '0; rsv_addr1 = '0;
    en_w1 = 1'b0; en_a1 = 1'b0; en_b1 = 1'b0; en_d1 = 1'b0; rsv_en1 = 1'b0;
    clear_model();
    do_reset("reset");

    // Basic write, read latency and hold.
    step(0, 1, 1, 625, 3'b000, 0, 0, 0, 0, 0, "w_r1");
    step(0, 0, 0, 0,   3'b001, 1, 0, 0, 0, 0, "rd_r1");
    step(0, 0, 0, 0,   3'b000, 0, 0, 0, 0, 0, "hold");
    // Bypass, three ports, same address on all ports.
    step(0, 1, 1, 626, 3'b001, 1, 0, 0, 0, 0, "bypass");
    step(0, 1, 2, 12,  3'b000, 0, 0, 0, 0, 0, "w_r2");
    step(0, 1, 0, 0,   3'b000, 0, 0, 0, 0, 0, "w_r0");
    step(0, 0, 0, 0,   3'b111, 1, 0, 2, 0, 0, "three");
    step(0, 0, 0, 0,   3'b111, 1, 1, 1, 0, 0, "same_addr");
    // Scoreboard.
    step(0, 0, 0, 0,   3'b000, 0, 0, 0, 1, 3, "rsv_r3");
    step(0, 0, 0, 0,   3'b001, 3, 0, 0, 0, 0, "rd_busy");
    step(0, 0, 0, 0,   3'b000, 0, 0, 0, 1, 3, "rsv_again");
    step(0, 0, 0, 0,   3'b000, 0, 0, 0, 0, 0, "err_drop");
    step(0, 1, 3, 7,   3'b001, 3, 0, 0, 0, 0, "w_r3");
    step(0, 1, 3, 9,   3'b001, 3, 0, 0, 1, 3, "rsv_w_r3");
    step(0, 0, 0, 0,   3'b001, 3, 0, 0, 0, 0, "rd_r3");
    step(0, 1, 3, 11,  3'b000, 0, 0, 0, 1, 4, "split");
    step(0, 1, 4, 1,   3'b000, 0, 0, 0, 0, 0, "clr_r4");
    step(0, 0, 0, 0,   3'b000, 0, 0, 0, 1, 1, "rsv_r1");
    step(0, 0, 0, 0,   3'b001, 1, 0, 0, 1, 2, "rsv_r2");

    // Asynchronous reset between edges, observed before the next rising edge.
    #2 reset = 1'b1;
    #1;
    chk_outputs_zero("async");
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    step(0, 0, 0, 0, 3'b111, 1, 3, 4, 0, 0, "post_rst");

    // No-bypass, zero-register instance.
    step(1, 1, 1, 625, 3'b000, 0, 0, 0, 0, 0, "p_w_r1");
    step(1, 1, 1, 626, 3'b100, 0, 0, 1, 0, 0, "nobyp");
    step(1, 0, 0, 0,   3'b100, 0, 0, 1, 0, 0, "nobyp2");
    step(1, 1, 0, 99,  3'b010, 0, 0, 0, 0, 0, "zr_w");
    step(1, 0, 0, 0,   3'b010, 0, 0, 0, 1, 0, "zr_rsv");
    step(1, 0, 0, 0,   3'b000, 0, 0, 0, 1, 0, "zr_rsv2");
    step(1, 0, 0, 0,   3'b000, 0, 0, 0, 1, 5, "rsv_r5");
    step(1, 1, 5, 3,   3'b001, 5, 0, 0, 0, 0, "nobyp_busy");
    step(1, 0, 0, 0,   3'b001, 5, 0, 0, 0, 0, "rd_r5");

    do_reset("reset2");
    step(1, 1, 31, 32'hDEAD_BEEF, 3'b000, 0, 0, 0, 0, 0, "w_r31");
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 3'b100, 0, 0, i, 0, 0, "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 8x16 three-read/one-write register file.
- Width and depth are configurable. Adds an optional hardwired zero register, same-cycle write-to-read bypass, registered read ports with valid flags, and a per-register busy scoreboard for in-flight results.
- Sits between the decoder (addresses, reservations) and the ALU/writeback path (bus_w).

Parameters:
WIDTH, 16, data width of every bus
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 always reads 0; writes and reservations to it are ignored
BYPASS, 1, 1 = a read of the address being written this cycle returns bus_w; 0 = returns old contents

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
bus_w  input  WIDTH  write data
addr_w  input  ADDR_W  write address
en_w  input  1  write enable
addr_a / addr_b / addr_d  input  ADDR_W  read addresses, ports a, b, d
en_a / en_b / en_d  input  1  read enables
bus_a / bus_b / bus_d  output  WIDTH  registered read data
valid_a / valid_b / valid_d  output  1  read data updated last edge
busy_a / busy_b / busy_d  output  1  sampled register was reserved (stale)
rsv_en  input  1  reserve request (mark register pending)
rsv_addr  input  ADDR_W  register to reserve
rsv_err  output  1  one-cycle pulse: reserve hit an already-busy register
busy_vec  output  DEPTH  live scoreboard, bit i = register i busy

Behaviour:
- Reset (async, any time, including mid-operation):
  - all DEPTH registers = 0
  - busy_vec = 0
  - bus_a/b/d = 0
  - valid_a/b/d = 0
  - busy_a/b/d = 0
  - rsv_err = 0
  - Reset dominates every same-edge request.
- Write: on an edge with en_w=1, reg[addr_w] <= bus_w. Exception: ZERO_REG=1 and addr_w=0, where the write is discarded.
- Read, per port x in {a, b, d}:
  - 1-cycle latency: inputs are sampled at edge N; results appear after edge N.
  - en_x=1: bus_x <= data, valid_x <= 1, busy_x <= sampled busy.
  - en_x=0: bus_x and busy_x hold their previous values; valid_x <= 0.
  - Data source: bus_w if BYPASS=1, en_w=1 and addr_w==addr_x (and not the discarded zero-register case). Otherwise reg[addr_x]. Always 0 if ZERO_REG=1 and addr_x=0.
  - Ports are fully independent. All three may read the same address.
- Scoreboard:
  - rsv_en=1: busy_vec[rsv_addr] <= 1.
  - en_w=1: busy_vec[addr_w] <= 0.
  - Same edge, same address, both set: reserve wins (bit = 1), and the write data is still stored.
  - Same edge, different addresses: both take effect.
  - ZERO_REG=1: bit 0 is always 0, and reserving register 0 never errors.
  - rsv_err <= rsv_en and busy_vec[rsv_addr] at the edge (pre-update value). The bit stays 1.
  - A write to a non-busy register is legal and raises no error.
- busy_x sampling:
  - Uses the post-write, pre-reserve view. A same-cycle write to addr_x clears it; a same-cycle reserve of addr_x does not set it.
  - BYPASS=0: busy_x uses the pre-edge busy_vec bit.
- Wrap-around: none. Addresses are full range 0..DEPTH-1 and no out-of-range case exists.

Test Plan:
1. Defaults, reset, write r1=625, en_a=1 addr_a=1 -> the edge after the read enable gives bus_a=625, valid_a=1; next cycle with en_a=0 -> bus_a holds 625, valid_a=0.
2. Bypass: reg1=625, same cycle en_w=1 addr_w=1 bus_w=626 and en_a=1 addr_a=1 -> bus_a=626. Repeat with BYPASS=0 -> bus_a=625, then 626 on the next read.
3. Three ports: r2=12, r1=626, r0=0; addr_a=1 addr_b=0 addr_d=2, all enabled -> 626 / 0 / 12. With ZERO_REG=1, a write of 99 to r0 -> bus_b still 0.
4. Scoreboard: reserve r3 -> busy_vec=0x08; a read of r3 -> busy_a=1. Reserve r3 again -> rsv_err pulses for exactly 1 cycle. Write r3=7 -> busy_vec=0. Same-edge reserve+write r3 -> busy_vec bit 3 = 1, r3 = new data.
5. Async reset mid-operation: reset asserted between edges while r1=626 and busy_vec=0x06 -> outputs 0 and busy_vec=0 immediately, without waiting for a clock edge. After release, a read of r1 returns 0.
6. Parametrisation: WIDTH=32, ADDR_W=5 -> write 0xDEADBEEF to r31, read it on port d -> 0xDEADBEEF; the other 31 registers read 0.
